id_ex_stage: RTL and testbench

//  ID/EX pipeline register and EX-stage operand selection feeding the ALU.

---
 rtl/id_ex_stage_pkg.sv | 33 +++
 rtl/id_ex_stage_fwd_sel.sv | 37 +++
 rtl/id_ex_stage.sv | 125 ++++++++++++
 tb/tb_id_ex_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// ==========================================================================
// Module : id_ex_stage_pkg
// Brief  : Shared widths, ALU opcode encodings and EX control bundle.
// Rev    : 1.0  initial release
// ==========================================================================
`default_nettype none

package id_ex_stage_pkg;

  localparam int c_width = 32;
  localparam int c_raw   = 5;

  localparam logic [3:0] c_alu_and     = 4'b0000;
  localparam logic [3:0] c_alu_or      = 4'b0001;
  localparam logic [3:0] c_alu_add     = 4'b0010;
  localparam logic [3:0] c_alu_xor     = 4'b0011;
  localparam logic [3:0] c_alu_sub     = 4'b0110;
  localparam logic [3:0] c_alu_slt     = 4'b0111;
  localparam logic [3:0] c_alu_badd    = 4'b1000;
  localparam logic [3:0] c_alu_badd_s  = 4'b1001;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [3:0] alu_control;
  } ex_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_fwd_sel.sv
// ==========================================================================
// Module : id_ex_stage_fwd_sel
// Brief  : Operand bypass select; EX/MEM beats MEM/WB, r0 never bypassed.
// Rev    : 1.0  initial release
// ==========================================================================
`default_nettype none

module id_ex_stage_fwd_sel #(
  parameter int WIDTH = 32,
  parameter int RAW   = 5
) (
  input  logic [RAW-1:0]   src_reg,
  input  logic [WIDTH-1:0] src_val,
  input  logic             exm_reg_write,
  input  logic [RAW-1:0]   exm_rd,
  input  logic [WIDTH-1:0] exm_result,
  input  logic             mwb_reg_write,
  input  logic [RAW-1:0]   mwb_rd,
  input  logic [WIDTH-1:0] mwb_result,
  output logic [WIDTH-1:0] fwd_val
);

  logic w_exm_hit;
  logic w_mwb_hit;

  assign w_exm_hit = exm_reg_write && (exm_rd != '0) && (exm_rd == src_reg);
  assign w_mwb_hit = mwb_reg_write && (mwb_rd != '0) && (mwb_rd == src_reg);

  always_comb begin
    fwd_val = src_val;
    if (w_exm_hit)      fwd_val = exm_result;
    else if (w_mwb_hit) fwd_val = mwb_result;
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ==========================================================================
// Module : id_ex_stage
// Brief  : ID/EX pipeline register with bypass, stall refresh and flush.
// Rev    : 1.0  initial release
// ==========================================================================
`default_nettype none

module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int WIDTH = c_width,
  parameter int RAW   = c_raw
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_rd1,
  input  logic [WIDTH-1:0] in_rd2,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [RAW-1:0]   in_rs,
  input  logic [RAW-1:0]   in_rt,
  input  logic [RAW-1:0]   in_rd,
  input  logic [3:0]       in_alu_control,
  input  logic             in_alu_src,
  input  logic             in_reg_dst,
  input  logic             in_reg_write,
  input  logic             in_mem_write,
  input  logic             in_mem_to_reg,
  input  logic             exm_reg_write,
  input  logic [RAW-1:0]   exm_rd,
  input  logic [WIDTH-1:0] exm_result,
  input  logic             mwb_reg_write,
  input  logic [RAW-1:0]   mwb_rd,
  input  logic [WIDTH-1:0] mwb_result,
  output logic [WIDTH-1:0] srcA,
  output logic [WIDTH-1:0] srcB,
  output logic [3:0]       ALUControl,
  output logic             out_valid,
  output logic [RAW-1:0]   out_wreg,
  output logic [WIDTH-1:0] out_store_data,
  output logic             out_reg_write,
  output logic             out_mem_write,
  output logic             out_mem_to_reg
);

  ex_ctrl_t         r_ctrl;
  logic [WIDTH-1:0] r_rd1;
  logic [WIDTH-1:0] r_rd2;
  logic [WIDTH-1:0] r_imm;
  logic [RAW-1:0]   r_rs;
  logic [RAW-1:0]   r_rt;
  logic [RAW-1:0]   r_wreg;
  logic [WIDTH-1:0] w_fwd_a;
  logic [WIDTH-1:0] w_fwd_b;

  id_ex_stage_fwd_sel #(.WIDTH(WIDTH), .RAW(RAW)) u_fwd_a (
    .src_reg(r_rs), .src_val(r_rd1),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .fwd_val(w_fwd_a)
  );

  id_ex_stage_fwd_sel #(.WIDTH(WIDTH), .RAW(RAW)) u_fwd_b (
    .src_reg(r_rt), .src_val(r_rd2),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .fwd_val(w_fwd_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl <= '0;
      r_rd1  <= '0;
      r_rd2  <= '0;
      r_imm  <= '0;
      r_rs   <= '0;
      r_rt   <= '0;
      r_wreg <= '0;
    end else if (flush) begin
      r_ctrl.valid       <= 1'b0;
      r_ctrl.reg_write   <= 1'b0;
      r_ctrl.mem_write   <= 1'b0;
      r_ctrl.mem_to_reg  <= 1'b0;
      r_ctrl.alu_control <= '0;
      r_rs               <= '0;
      r_rt               <= '0;
      r_wreg             <= '0;
    end else if (stall) begin
      // Latch bypassed operands so a producer retiring mid-stall is not lost.
      if (r_ctrl.valid) begin
        r_rd1 <= w_fwd_a;
        r_rd2 <= w_fwd_b;
      end
    end else begin
      r_ctrl.valid       <= in_valid;
      r_ctrl.reg_write   <= in_reg_write;
      r_ctrl.mem_write   <= in_mem_write;
      r_ctrl.mem_to_reg  <= in_mem_to_reg;
      r_ctrl.alu_src     <= in_alu_src;
      r_ctrl.alu_control <= in_alu_control;
      r_rd1              <= in_rd1;
      r_rd2              <= in_rd2;
      r_imm              <= in_imm;
      r_rs               <= in_rs;
      r_rt               <= in_rt;
      r_wreg             <= in_reg_dst ? in_rd : in_rt;
    end
  end

  assign srcA           = w_fwd_a;
  assign srcB           = r_ctrl.alu_src ? r_imm : w_fwd_b;
  assign out_store_data = w_fwd_b;
  assign ALUControl     = r_ctrl.alu_control;
  assign out_valid      = r_ctrl.valid;
  assign out_wreg       = r_wreg;
  // Bubbles never commit, whatever control bits were captured.
  assign out_reg_write  = r_ctrl.reg_write  & r_ctrl.valid;
  assign out_mem_write  = r_ctrl.mem_write  & r_ctrl.valid;
  assign out_mem_to_reg = r_ctrl.mem_to_reg & r_ctrl.valid;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ==========================================================================
// Module : tb_id_ex_stage
// Brief  : Directed self-checking bench for id_ex_stage.
// Rev    : 1.0  initial release
// ==========================================================================
`default_nettype none

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid;
  logic [31:0] in_rd1, in_rd2, in_imm;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [3:0]  in_alu_control;
  logic        in_alu_src, in_reg_dst, in_reg_write, in_mem_write, in_mem_to_reg;
  logic        exm_reg_write, mwb_reg_write;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_result;
  logic [31:0] srcA, srcB, out_store_data;
  logic [3:0]  ALUControl;
  logic        out_valid, out_reg_write, out_mem_write, out_mem_to_reg;
  logic [4:0]  out_wreg;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_alu_control(in_alu_control), .in_alu_src(in_alu_src), .in_reg_dst(in_reg_dst),
    .in_reg_write(in_reg_write), .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .srcA(srcA), .srcB(srcB), .ALUControl(ALUControl), .out_valid(out_valid),
    .out_wreg(out_wreg), .out_store_data(out_store_data),
    .out_reg_write(out_reg_write), .out_mem_write(out_mem_write),
    .out_mem_to_reg(out_mem_to_reg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] rs, input logic [31:0] rd1,
                      input logic [4:0] rt, input logic [31:0] rd2,
                      input logic [4:0] rd, input logic [31:0] imm,
                      input logic [3:0] op, input logic asrc, input logic rdst);
    in_valid = 1'b1; in_rs = rs; in_rd1 = rd1; in_rt = rt; in_rd2 = rd2;
    in_rd = rd; in_imm = imm; in_alu_control = op; in_alu_src = asrc; in_reg_dst = rdst;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_rd1 = '0; in_rd2 = '0; in_imm = '0;
    in_rs = '0; in_rt = '0; in_rd = '0; in_alu_control = '0;
    in_alu_src = 1'b0; in_reg_dst = 1'b0;
    in_reg_write = 1'b0; in_mem_write = 1'b0; in_mem_to_reg = 1'b0;
    exm_reg_write = 1'b0; exm_rd = '0; exm_result = '0;
    mwb_reg_write = 1'b0; mwb_rd = '0; mwb_result = '0;
    step(); step();
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_aluctl", {28'b0, ALUControl}, 32'd0);
    check("rst_srcA", srcA, 32'd0);
    check("rst_srcB", srcB, 32'd0);

    // EX/MEM takes priority over MEM/WB on rs
    reset = 1'b0;
    load(5'd3, 32'd5, 5'd4, 32'd6, 5'd9, 32'h0, 4'b0010, 1'b0, 1'b1);
    in_reg_write = 1'b1;
    exm_reg_write = 1'b1; exm_rd = 5'd3; exm_result = 32'd99;
    mwb_reg_write = 1'b1; mwb_rd = 5'd3; mwb_result = 32'd7;
    step();
    check("fwd_exm_srcA", srcA, 32'd99);
    check("nofwd_srcB", srcB, 32'd6);
    check("load_aluctl", {28'b0, ALUControl}, 32'h2);
    check("load_wreg_rd", {27'b0, out_wreg}, 32'd9);
    check("load_valid", {31'b0, out_valid}, 32'd1);
    check("load_regwrite", {31'b0, out_reg_write}, 32'd1);
    exm_reg_write = 1'b0; #1;
    check("fwd_mwb_srcA", srcA, 32'd7);
    mwb_reg_write = 1'b0; #1;
    check("nofwd_srcA", srcA, 32'd5);

    // register 0 is never bypassed; reg_dst=0 selects rt
    load(5'd0, 32'd0, 5'd4, 32'd6, 5'd9, 32'h0, 4'b0110, 1'b0, 1'b0);
    exm_reg_write = 1'b1; exm_rd = 5'd0; exm_result = 32'd55;
    step();
    check("r0_srcA", srcA, 32'd0);
    check("wreg_rt", {27'b0, out_wreg}, 32'd4);
    exm_reg_write = 1'b0;

    // immediate on srcB, store data still bypassed from MEM/WB
    load(5'd1, 32'd1, 5'd8, 32'd1, 5'd2, 32'h10, 4'b0010, 1'b1, 1'b1);
    mwb_reg_write = 1'b1; mwb_rd = 5'd8; mwb_result = 32'h22;
    step();
    check("imm_srcB", srcB, 32'h10);
    check("store_fwd", out_store_data, 32'h22);

    // stall: MEM/WB match only on first stall edge must survive in rd2
    load(5'd1, 32'd1, 5'd8, 32'd1, 5'd2, 32'h10, 4'b0011, 1'b0, 1'b1);
    step();
    check("pre_stall_srcB", srcB, 32'h22);
    stall = 1'b1; mwb_result = 32'hAB;
    load(5'd5, 32'h77, 5'd6, 32'h55, 5'd7, 32'h99, 4'b0111, 1'b1, 1'b0);
    step();
    mwb_reg_write = 1'b0;
    step(); step();
    check("stall_refresh_srcB", srcB, 32'hAB);
    check("stall_hold_aluctl", {28'b0, ALUControl}, 32'h3);
    check("stall_hold_wreg", {27'b0, out_wreg}, 32'd2);
    check("stall_hold_srcA", srcA, 32'd1);

    // stall and flush on the same edge: flush wins
    flush = 1'b1;
    step();
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_regwrite", {31'b0, out_reg_write}, 32'd0);
    check("flush_memwrite", {31'b0, out_mem_write}, 32'd0);
    check("flush_aluctl", {28'b0, ALUControl}, 32'd0);
    check("flush_wreg", {27'b0, out_wreg}, 32'd0);
    stall = 1'b0; flush = 1'b0;
    load(5'd2, 32'h44, 5'd3, 32'h33, 5'd12, 32'h0, 4'b1001, 1'b0, 1'b0);
    in_mem_write = 1'b1; in_mem_to_reg = 1'b1;
    step();
    check("post_flush_valid", {31'b0, out_valid}, 32'd1);
    check("post_flush_memwrite", {31'b0, out_mem_write}, 32'd1);
    check("post_flush_memtoreg", {31'b0, out_mem_to_reg}, 32'd1);
    check("post_flush_srcB", srcB, 32'h33);
    check("post_flush_wreg", {27'b0, out_wreg}, 32'd3);

    // bubble: captured write enables are masked when in_valid=0
    in_valid = 1'b0;
    step();
    check("bubble_regwrite", {31'b0, out_reg_write}, 32'd0);
    check("bubble_memwrite", {31'b0, out_mem_write}, 32'd0);

    // mid-stream reset for one clock
    in_valid = 1'b1;
    step();
    exm_reg_write = 1'b1; exm_rd = 5'd0; exm_result = 32'hDEAD;
    reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0; in_mem_write = 1'b0; in_mem_to_reg = 1'b0;
    in_reg_write = 1'b0;
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_memwrite", {31'b0, out_mem_write}, 32'd0);
    check("midrst_aluctl", {28'b0, ALUControl}, 32'd0);
    check("midrst_srcA", srcA, 32'd0);
    check("midrst_srcB", srcB, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
